// File: rtl/serial_divider.sv
// ---------------------------------------------------------------------------
// serial_divider
//   Multi-cycle restoring divider: one quotient bit per clock, MSB first.
//   Sits beside the ALU adder/subtractor. Uses a start/busy/done handshake
//   so the controller can stall while a divide is in flight.
//
//   Optional feature macro: SERIAL_DIVIDER_SIGNED_EN
//     undefined : unsigned operands; no sign logic is built.
//     defined   : two's-complement operands. The core divides magnitudes,
//                 then signs are fixed on the DONE edge (latency unchanged).
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        divide request, sampled only in IDLE or DONE
//   dividend     numerator   (bit 0 = LSB)
//   divisor      denominator (bit 0 = LSB)
//   busy         high while quotient bits are being produced
//   done         one-cycle pulse when results become valid
//   quotient     result quotient, held until the next result
//   remainder    result remainder, held until the next result
//   div_by_zero  set when the last completed divide had a zero divisor
// ---------------------------------------------------------------------------
module serial_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;      // dividend bits still to enter P
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH:0]     part_q, part_d;        // partial remainder P
    logic [WIDTH-1:0]   qsr_q, qsr_d;          // quotient shift register Q
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;

`ifdef SERIAL_DIVIDER_SIGNED_EN
    logic               q_neg_q, q_neg_d;      // quotient needs negation
    logic               r_neg_q, r_neg_d;      // remainder follows dividend sign
`endif

    // One restoring step: shift in the next dividend bit, trial-subtract.
    logic [WIDTH:0]     part_shift;
    logic [WIDTH:0]     part_next;
    logic               take;
    logic [WIDTH-1:0]   qsr_next;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;

    always_comb begin
        part_shift = {part_q[WIDTH-1:0], shift_q[WIDTH-1]};
        take       = (part_shift >= {1'b0, divisor_q});
        part_next  = take ? (part_shift - {1'b0, divisor_q}) : part_shift;
        qsr_next   = {qsr_q[WIDTH-2:0], take};
    end

    // Operand magnitudes fed to the unsigned core.
    always_comb begin
`ifdef SERIAL_DIVIDER_SIGNED_EN
        dvd_mag = dividend[WIDTH-1] ? (-dividend) : dividend;
        dvs_mag = divisor[WIDTH-1]  ? (-divisor)  : divisor;
`else
        dvd_mag = dividend;
        dvs_mag = divisor;
`endif
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        part_d    = part_q;
        qsr_d     = qsr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
`ifdef SERIAL_DIVIDER_SIGNED_EN
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
`endif
        case (state_q)
            RUN: begin
                shift_d = shift_q << 1;
                part_d  = part_next;
                qsr_d   = qsr_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef SERIAL_DIVIDER_SIGNED_EN
                    quot_d  = q_neg_q ? (-qsr_next) : qsr_next;
                    rem_d   = r_neg_q ? (-part_next[WIDTH-1:0]) : part_next[WIDTH-1:0];
`else
                    quot_d  = qsr_next;
                    rem_d   = part_next[WIDTH-1:0];
`endif
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor finishes immediately without RUN cycles.
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d   = RUN;
                        busy_d    = 1'b1;
                        shift_d   = dvd_mag;
                        divisor_d = dvs_mag;
                        part_d    = '0;
                        qsr_d     = '0;
`ifdef SERIAL_DIVIDER_SIGNED_EN
                        q_neg_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_d   = dividend[WIDTH-1];
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            divisor_q <= '0;
            part_q    <= '0;
            qsr_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
`ifdef SERIAL_DIVIDER_SIGNED_EN
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            part_q    <= part_d;
            qsr_q     <= qsr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
`ifdef SERIAL_DIVIDER_SIGNED_EN
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_divider.sv
// ---------------------------------------------------------------------------
// tb_serial_divider
//   Directed-vector bench for serial_divider (WIDTH = 8). Each scenario task
//   drives stimulus and checks outputs against hand-computed values.
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_serial_divider;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'h00;
    logic [7:0] divisor = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    serial_divider #(.WIDTH(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one divide and wait (bounded) for done. lat counts edges from
    // the accepting edge (1 = done visible right after the accepting edge).
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
        start = 1'b1; dividend = a; divisor = b;
        tick();
        start = 1'b0; dividend = 8'hC3; divisor = 8'h3C;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dbz=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        int lat;
        int busy_cnt;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
`ifdef SERIAL_DIVIDER_SIGNED_EN
        exp_q = 8'hF8; exp_r = 8'h00;   // -56 / 7
`else
        exp_q = 8'd28; exp_r = 8'd4;    // 200 / 7
`endif
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        tick();
        start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        lat = 1; busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        vectors++;
        if (lat != 9) begin
            miscompares++;
            $display("FAIL normal_latency got %0d want 9", lat);
        end
        vectors++;
        if (busy_cnt != 8) begin
            miscompares++;
            $display("FAIL normal_busy_cycles got %0d want 8", busy_cnt);
        end
        vectors++;
        if (quotient !== exp_q || remainder !== exp_r || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL normal_result got q=%h r=%h dbz=%b busy=%b want q=%h r=%h dbz=0 busy=0",
                     quotient, remainder, div_by_zero, busy, exp_q, exp_r);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || quotient !== exp_q) begin
            miscompares++;
            $display("FAIL normal_done_pulse got done=%b q=%h want done=0 q=%h", done, quotient, exp_q);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        int seen_busy;
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();      // now in RUN cycle 4
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrun_busy got %b want 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            miscompares++;
            $display("FAIL midrun_async_reset got busy=%b done=%b q=%h r=%h dbz=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        tick();
        tick();
        #3 reset_n = 1'b1;
        seen_done = 0; seen_busy = 0;
        repeat (15) begin
            tick();
            if (done === 1'b1) seen_done++;
            if (busy === 1'b1) seen_busy++;
        end
        vectors++;
        if (seen_done != 0 || seen_busy != 0) begin
            miscompares++;
            $display("FAIL midrun_no_result got done_cycles=%0d busy_cycles=%0d want 0 0",
                     seen_done, seen_busy);
        end
    endtask

    task automatic test_zero_divisor();
        int lat;
        run_div(8'h5A, 8'h00, lat);
        vectors++;
        if (lat != 1) begin
            miscompares++;
            $display("FAIL zero_latency got %0d want 1", lat);
        end
        vectors++;
        if (quotient !== 8'hFF || remainder !== 8'h5A || div_by_zero !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_result got q=%h r=%h dbz=%b busy=%b want q=ff r=5a dbz=1 busy=0",
                     quotient, remainder, div_by_zero, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_after got done=%b busy=%b dbz=%b want 0 0 1", done, busy, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start = 1'b1; dividend = 8'd100; divisor = 8'd10;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; dividend = 8'd50; divisor = 8'd3;   // must be ignored in RUN
        tick();
        start = 1'b0;
        lat = 4;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat != 9 || quotient !== 8'd10 || remainder !== 8'd0) begin
            miscompares++;
            $display("FAIL handshake_first got lat=%0d q=%h r=%h want lat=9 q=0a r=00",
                     lat, quotient, remainder);
        end
        // Start again in the DONE cycle.
        start = 1'b1; dividend = 8'd255; divisor = 8'd255;
        tick();
        start = 1'b0; dividend = 8'd3; divisor = 8'd2;
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0 || quotient !== 8'd10 || remainder !== 8'd0) begin
            miscompares++;
            $display("FAIL handshake_hold got busy=%b done=%b q=%h r=%h want busy=1 done=0 q=0a r=00",
                     busy, done, quotient, remainder);
        end
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat != 9 || quotient !== 8'd1 || remainder !== 8'd0) begin
            miscompares++;
            $display("FAIL handshake_second got lat=%0d q=%h r=%h want lat=9 q=01 r=00",
                     lat, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_boundaries();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] vq [4];
        logic [7:0] vr [4];
        int lat;
        va = '{8'd13, 8'd0, 8'd255, 8'd255};
        vb = '{8'd200, 8'd5, 8'd1, 8'd16};
`ifdef SERIAL_DIVIDER_SIGNED_EN
        // 13/-56, 0/5, -1/1, -1/16
        vq = '{8'd0, 8'd0, 8'hFF, 8'd0};
        vr = '{8'd13, 8'd0, 8'd0, 8'hFF};
`else
        vq = '{8'd0, 8'd0, 8'd255, 8'd15};
        vr = '{8'd13, 8'd0, 8'd0, 8'd15};
`endif
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], lat);
            vectors++;
            if (lat != 9 || quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0) begin
                miscompares++;
                $display("FAIL boundary_%0d %0d/%0d got lat=%0d q=%h r=%h dbz=%b want lat=9 q=%h r=%h dbz=0",
                         i, va[i], vb[i], lat, quotient, remainder, div_by_zero, vq[i], vr[i]);
            end
            tick();
        end
    endtask

`ifdef SERIAL_DIVIDER_SIGNED_EN
    task automatic test_signed();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vq [3];
        logic [7:0] vr [3];
        int lat;
        va = '{8'hF9, 8'h07, 8'h80};
        vb = '{8'h02, 8'hFE, 8'hFF};
        vq = '{8'hFD, 8'hFD, 8'h80};
        vr = '{8'hFF, 8'h01, 8'h00};
        for (int i = 0; i < 3; i++) begin
            run_div(va[i], vb[i], lat);
            vectors++;
            if (lat != 9 || quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0) begin
                miscompares++;
                $display("FAIL signed_%0d %h/%h got lat=%0d q=%h r=%h dbz=%b want lat=9 q=%h r=%h dbz=0",
                         i, va[i], vb[i], lat, quotient, remainder, div_by_zero, vq[i], vr[i]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_reset_mid_run();
        test_zero_divisor();
        test_back_to_back();
        test_boundaries();
`ifdef SERIAL_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
